// File: rtl/key_conditioner.sv
// key_conditioner: synchronize, debounce and auto-repeat a bank of board keys/switches
module key_conditioner #(
   parameter int N_KEYS          = 4,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic [N_KEYS-1:0] raw,
   input  logic [N_KEYS-1:0] repeat_en,
   output logic [N_KEYS-1:0] level,
   output logic [N_KEYS-1:0] press,
   output logic [N_KEYS-1:0] release_pulse,
   output logic [N_KEYS-1:0] event_pulse,
   output logic              any_event
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX);
   typedef enum logic [1:0] {IDLE, HELD_DELAY, HELD_REPEAT} rpt_state_t;
   logic [N_KEYS-1:0] s1, s2, a, accept, rpt_due, ev_next;
   logic [DW-1:0]     db_cnt [N_KEYS];
   logic [RW-1:0]     rc     [N_KEYS];
   rpt_state_t        state  [N_KEYS];
   // per-channel acceptance and repeat-due decisions; a release always masks a coincident repeat
   always_comb begin
      a       = s2 ^ {N_KEYS{ACTIVE_LOW}};
      accept  = '0;
      rpt_due = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         accept[i]  = (a[i] != level[i]) && (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
         rpt_due[i] = repeat_en[i] &&
                      ((state[i] == HELD_DELAY  && rc[i] == RW'(REPEAT_DELAY - 1)) ||
                       (state[i] == HELD_REPEAT && rc[i] == RW'(REPEAT_PERIOD - 1)));
      end
      ev_next = (accept & ~level) | (rpt_due & ~accept);
   end
   // synchronizer, debounce counters, repeat FSMs and registered pulse outputs
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         s1            <= {N_KEYS{ACTIVE_LOW}};
         s2            <= {N_KEYS{ACTIVE_LOW}};
         level         <= '0;
         press         <= '0;
         release_pulse <= '0;
         event_pulse   <= '0;
         any_event     <= 1'b0;
         for (int i = 0; i < N_KEYS; i++) begin
            db_cnt[i] <= '0;
            rc[i]     <= '0;
            state[i]  <= IDLE;
         end
      end else begin
         s1            <= raw;
         s2            <= s1;
         level         <= level ^ accept;
         press         <= accept & ~level;
         release_pulse <= accept & level;
         event_pulse   <= ev_next;
         any_event     <= |ev_next;
         for (int i = 0; i < N_KEYS; i++) begin
            db_cnt[i] <= (a[i] == level[i] || accept[i]) ? '0 : db_cnt[i] + 1'b1;
            if (accept[i]) begin
               state[i] <= level[i] ? IDLE : HELD_DELAY;
               rc[i]    <= '0;
            end else if (state[i] != IDLE && !repeat_en[i]) begin
               state[i] <= HELD_DELAY;
               rc[i]    <= '0;
            end else if (rpt_due[i]) begin
               state[i] <= HELD_REPEAT;
               rc[i]    <= '0;
            end else if (state[i] != IDLE) begin
               rc[i]    <= rc[i] + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, glitch rejection, auto-repeat and reset
module tb_key_conditioner;
   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] raw, repeat_en, level, press, release_pulse, event_pulse;
   logic       any_event;
   logic [63:0] hist, rel_hist;
   logic        seen;
   int checks = 0;
   int errors = 0;

   key_conditioner #(
      .N_KEYS(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .raw(raw), .repeat_en(repeat_en),
      .level(level), .press(press), .release_pulse(release_pulse),
      .event_pulse(event_pulse), .any_event(any_event)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; raw = 4'hF; repeat_en = 4'h0;
      tick(3);
      check("reset_outputs", 64'({level, press, release_pulse, event_pulse, any_event}), 64'd0);
      // clean press on channel 0, raw falls in cycle 0
      reset = 1'b0; raw[0] = 1'b0;
      tick(5);
      check("c5_level", 64'(level), 64'd0);
      check("c5_press", 64'(press), 64'd0);
      tick();
      check("c6_level", 64'(level), 64'b0001);
      check("c6_press", 64'(press), 64'b0001);
      check("c6_event", 64'(event_pulse), 64'b0001);
      check("c6_any", 64'(any_event), 64'd1);
      tick();
      check("c7_press", 64'(press), 64'd0);
      check("c7_event", 64'(event_pulse), 64'd0);
      check("c7_level", 64'(level), 64'b0001);
      raw[0] = 1'b1;
      tick(5);
      check("rel_early", 64'(release_pulse), 64'd0);
      tick();
      check("rel_pulse", 64'(release_pulse), 64'b0001);
      check("rel_level", 64'(level), 64'd0);
      check("rel_no_event", 64'(event_pulse), 64'd0);
      tick();
      check("rel_one_cycle", 64'(release_pulse), 64'd0);
      // glitch on channel 1: low 3 cycles, high 1, then low held from cycle 4
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         raw[1] = (c == 3);
         seen |= press[1];
         tick();
      end
      check("glitch_no_press", 64'(seen), 64'd0);
      check("glitch_press", 64'(press), 64'b0010);
      raw[1] = 1'b1;
      tick(8);
      check("glitch_released", 64'(level), 64'd0);
      // auto-repeat on channel 2, release timed onto a due repeat
      repeat_en = 4'b0100; hist = '0; rel_hist = '0;
      for (int c = 0; c < 31; c++) begin
         hist[c]     = event_pulse[2];
         rel_hist[c] = release_pulse[2];
         raw[2] = (c >= 19);
         tick();
      end
      check("repeat_events", hist, (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 19) | (64'd1 << 22));
      check("repeat_release", rel_hist, 64'd1 << 25);
      check("repeat_idle_level", 64'(level), 64'd0);
      // repeat enable dropped mid-repeat then restored
      hist = '0;
      for (int c = 0; c < 35; c++) begin
         hist[c] = event_pulse[2];
         raw[2] = 1'b0;
         repeat_en[2] = !(c >= 17 && c < 20);
         tick();
      end
      check("reen_events", hist, (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 30) | (64'd1 << 33));
      raw[2] = 1'b1; repeat_en = 4'h0;
      tick(8);
      check("reen_released", 64'(level), 64'd0);
      // all keys held across reset release, then reset during repeat
      reset = 1'b1; raw = 4'h0; repeat_en = 4'hF;
      tick(3);
      check("held_reset_outputs", 64'({level, press, release_pulse, event_pulse, any_event}), 64'd0);
      reset = 1'b0; seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         seen |= |{level, press, release_pulse, event_pulse, any_event};
         tick();
      end
      check("held_quiet", 64'(seen), 64'd0);
      check("held_press", 64'(press), 64'hF);
      check("held_event", 64'(event_pulse), 64'hF);
      check("held_any", 64'(any_event), 64'd1);
      check("held_level", 64'(level), 64'hF);
      tick(10);
      check("all_repeat", 64'(event_pulse), 64'hF);
      check("all_repeat_no_press", 64'(press), 64'd0);
      tick();
      check("all_repeat_one_cycle", 64'(event_pulse), 64'd0);
      reset = 1'b1;
      tick();
      check("reset_mid_repeat", 64'({level, press, release_pulse, event_pulse, any_event}), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         seen |= |{level, press, release_pulse, event_pulse, any_event};
      end
      check("reset_hold_quiet", 64'(seen), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
